if_fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of if_stage_reg. It owns the PC, issues word fetches to instruction memory over a req/ready handshake, and presents each fetched instruction with its PC+4 to if_stage_reg. It honours the hazard unit's freeze and the EX-stage branch redirect. One outstanding memory request at a time, with a one-entry skid so no returned word is lost under freeze.

---
 rtl/if_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, runs one outstanding imem request at a time,
// and hands {PC+4, instruction} to if_stage_reg through a one-entry skid.
module if_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Branch_Taken,
  input  logic [DATA_WIDTH-1:0] i_Branch_Addr,
  output logic                  o_Imem_Req,
  output logic [DATA_WIDTH-1:0] o_Imem_Addr,
  input  logic                  i_Imem_Ready,
  input  logic [DATA_WIDTH-1:0] i_Imem_Data,
  output logic                  o_Valid,
  output logic [DATA_WIDTH-1:0] o_Pc,
  output logic [DATA_WIDTH-1:0] o_Instruction
);

  typedef enum logic [1:0] {REQ, SKID, DISCARD} state_t;

  localparam logic [DATA_WIDTH-1:0] WORD = DATA_WIDTH'(4);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] addr, redir, skid_pc, skid_instr;

  logic buf_free, consume;
  logic ld_mem, ld_skid, cap_skid, addr_inc, br_load, redir_load;

  assign consume  = o_Valid && !i_Freeze;
  assign buf_free = !o_Valid || !i_Freeze;

  // A returned word is only useful if no redirect lands on the same edge.
  assign ld_mem     = (state == REQ)  && i_Imem_Ready && !i_Branch_Taken && buf_free;
  assign cap_skid   = (state == REQ)  && i_Imem_Ready && !i_Branch_Taken && !buf_free;
  assign ld_skid    = (state == SKID) && !i_Branch_Taken && buf_free;
  assign addr_inc   = (state == REQ)  && i_Imem_Ready && !i_Branch_Taken;
  assign redir_load = (state == DISCARD) && i_Imem_Ready && !i_Branch_Taken;
  // Branch may move the address only when no request is left in flight.
  assign br_load    = i_Branch_Taken &&
                      ((state == SKID) || i_Imem_Ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_Imem_Req = 1'b0;
    case (state)
      REQ: begin
        o_Imem_Req = 1'b1;
        if (i_Branch_Taken)                state_nxt = i_Imem_Ready ? REQ : DISCARD;
        else if (i_Imem_Ready && !buf_free) state_nxt = SKID;
      end
      SKID: begin
        if (i_Branch_Taken || buf_free) state_nxt = REQ;
      end
      DISCARD: begin
        o_Imem_Req = 1'b1;
        if (i_Imem_Ready) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  assign o_Imem_Addr = addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr          <= RESET_PC;
      redir         <= '0;
      skid_pc       <= '0;
      skid_instr    <= '0;
      o_Valid       <= 1'b0;
      o_Pc          <= '0;
      o_Instruction <= '0;
    end else begin
      if (br_load)         addr <= i_Branch_Addr;
      else if (addr_inc)   addr <= addr + WORD;
      else if (redir_load) addr <= redir;

      // Latest branch target wins while the stale request drains.
      if (i_Branch_Taken) redir <= i_Branch_Addr;

      if (cap_skid) begin
        skid_pc    <= addr + WORD;
        skid_instr <= i_Imem_Data;
      end

      if (ld_mem) begin
        o_Pc          <= addr + WORD;
        o_Instruction <= i_Imem_Data;
      end else if (ld_skid) begin
        o_Pc          <= skid_pc;
        o_Instruction <= skid_instr;
      end

      if (i_Branch_Taken)        o_Valid <= 1'b0;
      else if (ld_mem || ld_skid) o_Valid <= 1'b1;
      else if (consume)          o_Valid <= 1'b0;
    end
  end

endmodule
